// File: rtl/cr_write_sched_if.sv
// cr_write_sched_if: requester handshake and CR write-port bundle for the CR write scheduler
interface cr_write_sched_if #(
  parameter int NREQ     = 3,
  parameter int CR_WIDTH = 32,
  parameter int NFIELD   = 8
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*NFIELD-1:0]   req_mask;
  logic [NREQ*CR_WIDTH-1:0] req_data;
  logic [CR_WIDTH-1:0]      cr_rd;
  logic                     cr_wr;
  logic [CR_WIDTH-1:0]      cr_wd;
  modport master (output req_valid, req_mask, req_data, cr_rd, input req_ready, cr_wr, cr_wd);
  modport slave  (input req_valid, req_mask, req_data, cr_rd, output req_ready, cr_wr, cr_wd);
endinterface

// File: rtl/cr_write_sched.sv
// cr_write_sched: rotating-priority merge of non-overlapping CR field updates onto one write port
module cr_write_sched #(
  parameter int NREQ     = 3,
  parameter int CR_WIDTH = 32,
  parameter int NFIELD   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold_i,
  cr_write_sched_if.slave    bus,
  output logic [NFIELD-1:0]  field_busy_o,
  output logic [15:0]        conflict_cnt_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]       ptr_q, ptr_d;
  logic                stg_v_q;
  logic [NFIELD-1:0]   stg_mask_q, acc;
  logic [CR_WIDTH-1:0] stg_data_q, data_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt;
  logic                first, deny;
  logic [PW:0]         sum;
  logic [PW-1:0]       idx;
  logic [NFIELD-1:0]   mask_a [NREQ];
  logic [CR_WIDTH-1:0] data_a [NREQ];

  function automatic logic [CR_WIDTH-1:0] expand(input logic [NFIELD-1:0] m);
    logic [CR_WIDTH-1:0] e;
    e = '0;
    for (int f = 0; f < NFIELD; f++) e[4*f +: 4] = {4{m[f]}};
    return e;
  endfunction

  for (genvar r = 0; r < NREQ; r++) begin : g_unpack
    assign mask_a[r] = bus.req_mask[r*NFIELD +: NFIELD];
    assign data_a[r] = bus.req_data[r*CR_WIDTH +: CR_WIDTH];
  end

  // Walk requesters from ptr, granting each whose fields don't collide with earlier grants
  always_comb begin
    gnt    = '0;
    acc    = '0;
    data_d = '0;
    ptr_d  = ptr_q;
    first  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
      if (rst_n && !hold_i && bus.req_valid[idx] && (mask_a[idx] & acc) == '0) begin
        gnt[idx] = 1'b1;
        acc      = acc | mask_a[idx];
        data_d   = data_d | (data_a[idx] & expand(mask_a[idx]));
        ptr_d    = first ? ptr_d : ((idx == PW'(NREQ-1)) ? '0 : idx + 1'b1);
        first    = 1'b1;
      end
    end
    deny  = !hold_i && |(bus.req_valid & ~gnt);
    cnt_d = (deny && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  // Stage the merged grant set, advance the pointer and count denied cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      stg_v_q    <= 1'b0;
      stg_mask_q <= '0;
      stg_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      stg_v_q    <= |gnt;
      stg_mask_q <= acc;
      stg_data_q <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.cr_wr       = stg_v_q & |stg_mask_q;
  assign bus.cr_wd       = (bus.cr_rd & ~expand(stg_mask_q)) | stg_data_q;
  assign field_busy_o    = stg_v_q ? stg_mask_q : '0;
  assign conflict_cnt_o  = cnt_q;
endmodule

// File: tb/tb_cr_write_sched.sv
// tb_cr_write_sched: directed and random checks of the CR write scheduler against a field-level model
module tb_cr_write_sched;
  logic clk = 1'b0, rst_n = 1'b0, hold = 1'b0;
  logic [7:0]  busy;
  logic [15:0] cnt;
  logic [31:0] cr_q = '0;
  int checks = 0, errors = 0;
  int m_ptr = 0, m_cnt = 0;
  logic m_sv = 1'b0;
  logic [7:0]  m_smask = '0;
  logic [31:0] m_sdata = '0, m_cr = '0;
  logic [2:0]  obs_ready;
  logic        obs_wr;
  logic [31:0] obs_wd;
  logic [7:0]  obs_busy;
  logic [15:0] obs_cnt;

  cr_write_sched_if bus();

  cr_write_sched dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold), .bus(bus),
    .field_busy_o(busy), .conflict_cnt_o(cnt)
  );

  assign bus.cr_rd = cr_q;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.cr_wr) cr_q <= bus.cr_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_sv = 1'b0; m_smask = '0; m_sdata = '0;
  endtask

  task automatic step(input logic h, input logic [2:0] v, input logic [23:0] m, input logic [95:0] d);
    logic [2:0]  eg;
    logic [7:0]  acc;
    logic [31:0] nd, ewd;
    logic        ewr, deny;
    int first;
    hold = h; bus.req_valid = v; bus.req_mask = m; bus.req_data = d;
    eg = '0; acc = '0; nd = '0; first = -1;
    if (!h) for (int k = 0; k < 3; k++) begin
      int r;
      r = (m_ptr + k) % 3;
      if (v[r] && (m[r*8 +: 8] & acc) == 8'h0) begin
        eg[r] = 1'b1;
        acc = acc | m[r*8 +: 8];
        if (first < 0) first = r;
        for (int f = 0; f < 8; f++) if (m[r*8+f]) nd[f*4 +: 4] = d[r*32 + f*4 +: 4];
      end
    end
    deny = !h && ((v & ~eg) != 3'b0);
    ewr = m_sv && (m_smask != 8'h0);
    for (int f = 0; f < 8; f++) ewd[f*4 +: 4] = (m_sv && m_smask[f]) ? m_sdata[f*4 +: 4] : m_cr[f*4 +: 4];
    @(negedge clk);
    obs_ready = bus.req_ready; obs_wr = bus.cr_wr; obs_wd = bus.cr_wd; obs_busy = busy; obs_cnt = cnt;
    chk("ready", 32'(obs_ready), 32'(eg));
    chk("cr_wr", 32'(obs_wr), 32'(ewr));
    if (ewr) chk("cr_wd", obs_wd, ewd);
    chk("field_busy", 32'(obs_busy), 32'(m_sv ? m_smask : 8'h0));
    chk("conflict_cnt", 32'(obs_cnt), 32'(m_cnt));
    chk("cr_reg", cr_q, m_cr);
    @(posedge clk);
    if (ewr) m_cr = ewd;
    if (eg != 3'b0) begin
      m_sv = 1'b1; m_smask = acc; m_sdata = nd; m_ptr = (first + 1) % 3;
    end else begin
      m_sv = 1'b0; m_smask = '0; m_sdata = '0;
    end
    if (deny && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'b000, 24'h0, 96'h0);
  endtask

  initial begin
    logic [31:0] save;
    logic [15:0] c0;
    logic        w1, w2;
    bus.req_valid = '0; bus.req_mask = '0; bus.req_data = '0;
    #12;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_cr_wr", 32'(bus.cr_wr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // single request
    step(1'b0, 3'b001, {8'h00, 8'h00, 8'h80}, {32'h0, 32'h0, 32'h4000_0000});
    chk("t1_ready", 32'(obs_ready), 32'h1);
    idle();
    chk("t1_wr", 32'(obs_wr), 32'h1);
    chk("t1_wd", obs_wd, 32'h4000_0000);
    chk("t1_busy", 32'(obs_busy), 32'h80);
    idle();
    chk("t1_busy_clr", 32'(obs_busy), 32'h0);
    // fill CR with ones through requester 2, leaving ptr at 0
    step(1'b0, 3'b100, {8'hFF, 8'h00, 8'h00}, {32'hFFFF_FFFF, 32'h0, 32'h0});
    idle(); idle();
    chk("setup_cr", cr_q, 32'hFFFF_FFFF);
    // disjoint merge
    step(1'b0, 3'b011, {8'h00, 8'h04, 8'h80}, {32'h0, 32'h0000_0200, 32'h8000_0000});
    chk("t2_ready", 32'(obs_ready), 32'h3);
    idle();
    chk("t2_wd", obs_wd, 32'h8FFF_F2FF);
    idle();
    // zero-mask request: granted, no write, no conflict, ptr back to 0
    c0 = obs_cnt;
    step(1'b0, 3'b100, 24'h0, 96'h0);
    chk("zm_ready", 32'(obs_ready), 32'h4);
    idle();
    chk("zm_wr", 32'(obs_wr), 32'h0);
    chk("zm_cnt", 32'(obs_cnt), 32'(c0));
    // conflict rotation
    step(1'b0, 3'b011, {8'h00, 8'h80, 8'h80}, {32'h0, 32'h3000_0000, 32'hA000_0000});
    chk("t3_c0_ready", 32'(obs_ready), 32'h1);
    step(1'b0, 3'b010, {8'h00, 8'h80, 8'h80}, {32'h0, 32'h3000_0000, 32'hA000_0000});
    chk("t3_c1_ready", 32'(obs_ready), 32'h2);
    idle(); idle();
    chk("t3_cnt", 32'(obs_cnt), 32'(c0 + 16'd1));
    chk("t3_field0", 32'(cr_q[31:28]), 32'h3);
    // back-to-back same field
    save = cr_q;
    step(1'b0, 3'b100, {8'h01, 8'h00, 8'h00}, {32'h0000_0003, 32'h0, 32'h0});
    step(1'b0, 3'b100, {8'h01, 8'h00, 8'h00}, {32'h0000_0005, 32'h0, 32'h0});
    w1 = obs_wr;
    idle();
    w2 = obs_wr;
    chk("t4_wr_pair", 32'({w1, w2}), 32'h3);
    idle();
    chk("t4_cr", cr_q, {save[31:4], 4'h5});
    // hold with a staged write
    step(1'b0, 3'b001, {8'h00, 8'h00, 8'h40}, {32'h0, 32'h0, 32'h0700_0000});
    c0 = obs_cnt;
    step(1'b1, 3'b001, {8'h00, 8'h00, 8'h40}, {32'h0, 32'h0, 32'h0700_0000});
    chk("t5_hold_ready", 32'(obs_ready), 32'h0);
    chk("t5_retire", 32'(obs_wr), 32'h1);
    step(1'b1, 3'b001, {8'h00, 8'h00, 8'h40}, {32'h0, 32'h0, 32'h0700_0000});
    chk("t5_hold_ready2", 32'(obs_ready), 32'h0);
    step(1'b0, 3'b001, {8'h00, 8'h00, 8'h40}, {32'h0, 32'h0, 32'h0700_0000});
    chk("t5_release", 32'(obs_ready), 32'h1);
    idle();
    chk("t5_cnt", 32'(obs_cnt), 32'(c0));
    idle();
    // reset while a write is staged
    step(1'b0, 3'b010, {8'h00, 8'h02, 8'h00}, {32'h0, 32'h0000_0050, 32'h0});
    save = cr_q;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_mask = '0; bus.req_data = '0;
    #1;
    chk("t6_wr", 32'(bus.cr_wr), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_cnt", 32'(cnt), 32'h0);
    @(posedge clk); #1;
    chk("t6_cr_kept", cr_q, save);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    step(1'b0, 3'b110, {8'h02, 8'h02, 8'h00}, {32'h0000_0070, 32'h0000_0060, 32'h0});
    chk("t6_ptr0", 32'(obs_ready), 32'h2);
    idle(); idle();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [23:0] m;
      for (int r = 0; r < 3; r++) begin
        int sel;
        sel = $urandom_range(0, 3);
        m[r*8 +: 8] = (sel == 0) ? 8'h0 : (sel == 1) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      end
      step($urandom_range(0, 7) == 0, 3'($urandom), m, {$urandom, $urandom, $urandom});
    end
    idle(); idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
